matrix_lif_array: RTL and testbench

Parametrised matrix-wide leaky integrate-and-fire engine for the SNN datapath. It streams a source current matrix from on-chip memory and keeps a separate membrane potential per neuron in an internal state RAM. Each neuron applies leak, integration, saturation, threshold and reset, and the block writes one spike word per element to the destination memory. It replaces the single-shared-neuron LIF pass with a true per-element, multi-timestep engine and adds a selectable reset mode and spike statistics.

---
 rtl/matrix_lif_array.sv | 167 ++++++++++++++++
 tb/tb_matrix_lif_array.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_lif_array.sv
// Matrix-wide leaky integrate-and-fire engine: streams currents, updates a
// per-neuron membrane RAM and writes one spike word per matrix element.
module matrix_lif_array #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DIM_W       = 10,
    parameter int unsigned MAX_NEURONS = 1024,
    parameter int unsigned SHIFT_W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done,
    input  logic                     clear_state,
    input  logic                     reset_mode,
    input  logic [SHIFT_W-1:0]       leak_shift,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic [DIM_W-1:0]         row_size,
    input  logic [DIM_W-1:0]         col_size,
    input  logic [ADDR_W-1:0]        src_start_address,
    input  logic [ADDR_W-1:0]        dest_start_address,
    output logic [ADDR_W-1:0]        src_address,
    input  logic signed [DATA_W-1:0] src_readdata,
    output logic [ADDR_W-1:0]        dest_address,
    output logic [DATA_W-1:0]        dest_writedata,
    output logic                     dest_write_en,
    output logic [ADDR_W:0]          spike_count,
    output logic                     size_err
);

    localparam int unsigned N_W   = 2 * DIM_W;
    localparam int unsigned CNT_W = $clog2(MAX_NEURONS + 1);
    localparam int unsigned IDX_W = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
    localparam int unsigned EXT_W = DATA_W + 2;
    localparam int unsigned SC_W  = ADDR_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]         cfg_n;
    logic                     cfg_mode;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic signed [DATA_W-1:0] cfg_thr;
    logic [ADDR_W-1:0]        cfg_src;
    logic [ADDR_W-1:0]        cfg_dest;
    logic [CNT_W-1:0]         idx;
    logic                     drain_cnt;
    logic                     p1_valid;
    logic [IDX_W-1:0]         p1_idx;
    logic signed [DATA_W-1:0] v_rd;

    logic [N_W-1:0]           n_calc;
    logic                     size_bad;
    logic                     last;

    logic signed [EXT_W-1:0]  sum;
    logic signed [DATA_W-1:0] v_new;
    logic signed [DATA_W-1:0] v_store;
    logic                     spike;

    logic                     mem_we;
    logic [IDX_W-1:0]         mem_waddr;
    logic signed [DATA_W-1:0] mem_wdata;
    logic signed [DATA_W-1:0] vmem [MAX_NEURONS];

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] x);
        if (x > SAT_MAX) return DATA_W'(SAT_MAX);
        if (x < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(x);
    endfunction

    assign n_calc   = N_W'(row_size) * N_W'(col_size);
    assign size_bad = (n_calc == '0) || (n_calc > N_W'(MAX_NEURONS));
    assign last     = (idx == cfg_n - CNT_W'(1));

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start && !size_bad) state_next = clear_state ? S_CLEAR : S_RUN;
            S_CLEAR: if (last) state_next = S_RUN;
            S_RUN:   if (last) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Leak, integrate, saturate, fire and reset for the element in stage 2
    always_comb begin
        sum     = EXT_W'(v_rd) - EXT_W'(v_rd >>> cfg_shift) + EXT_W'(src_readdata);
        v_new   = sat(sum);
        spike   = (v_new >= cfg_thr);
        v_store = v_new;
        if (spike) v_store = cfg_mode ? sat(EXT_W'(v_new) - EXT_W'(cfg_thr)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            done           <= 1'b1;
            dest_write_en  <= 1'b0;
            dest_writedata <= '0;
            src_address    <= '0;
            dest_address   <= '0;
            spike_count    <= '0;
            size_err       <= 1'b0;
            cfg_n          <= '0;
            cfg_mode       <= 1'b0;
            cfg_shift      <= '0;
            cfg_thr        <= '0;
            cfg_src        <= '0;
            cfg_dest       <= '0;
            idx            <= '0;
            drain_cnt      <= 1'b0;
            p1_valid       <= 1'b0;
            p1_idx         <= '0;
        end else begin
            state    <= state_next;
            done     <= (state_next == S_IDLE);
            p1_valid <= (state == S_RUN);
            p1_idx   <= idx[IDX_W-1:0];
            case (state)
                S_IDLE: if (start) begin
                    spike_count <= '0;
                    size_err    <= size_bad;
                    cfg_n       <= CNT_W'(n_calc);
                    cfg_mode    <= reset_mode;
                    cfg_shift   <= leak_shift;
                    cfg_thr     <= threshold;
                    cfg_src     <= src_start_address;
                    cfg_dest    <= dest_start_address;
                    idx         <= '0;
                    drain_cnt   <= 1'b0;
                    src_address <= src_start_address;
                end
                S_CLEAR: idx <= last ? '0 : idx + CNT_W'(1);
                S_RUN: if (!last) begin
                    idx         <= idx + CNT_W'(1);
                    src_address <= cfg_src + ADDR_W'(idx) + ADDR_W'(1);
                end
                S_DRAIN: drain_cnt <= 1'b1;
                default: ;
            endcase
            dest_write_en <= p1_valid;
            if (p1_valid) begin
                dest_address   <= cfg_dest + ADDR_W'(p1_idx);
                dest_writedata <= DATA_W'(spike);
                spike_count    <= spike_count + SC_W'(spike);
            end
        end
    end

    // Membrane RAM: deliberately unreset so state survives passes and reset
    assign mem_we    = !reset && ((state == S_CLEAR) || p1_valid);
    assign mem_waddr = (state == S_CLEAR) ? idx[IDX_W-1:0] : p1_idx;
    assign mem_wdata = (state == S_CLEAR) ? '0 : v_store;

    always_ff @(posedge clk) begin
        if (mem_we) vmem[mem_waddr] <= mem_wdata;
        v_rd <= vmem[idx[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_matrix_lif_array.sv
// Bench for matrix_lif_array: table of passes with hand-derived spike counts,
// a reference LIF model feeding a write scoreboard, and reset/size corner cases.
module tb_matrix_lif_array;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               done;
    logic               clear_state = 1'b0;
    logic               reset_mode = 1'b0;
    logic [3:0]         leak_shift = '0;
    logic signed [15:0] threshold = '0;
    logic [9:0]         row_size = '0;
    logic [9:0]         col_size = '0;
    logic [13:0]        src_start_address = '0;
    logic [13:0]        dest_start_address = '0;
    logic [13:0]        src_address;
    logic signed [15:0] src_readdata = '0;
    logic [13:0]        dest_address;
    logic [15:0]        dest_writedata;
    logic               dest_write_en;
    logic [14:0]        spike_count;
    logic               size_err;

    matrix_lif_array dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .clear_state(clear_state), .reset_mode(reset_mode),
        .leak_shift(leak_shift), .threshold(threshold),
        .row_size(row_size), .col_size(col_size),
        .src_start_address(src_start_address), .dest_start_address(dest_start_address),
        .src_address(src_address), .src_readdata(src_readdata),
        .dest_address(dest_address), .dest_writedata(dest_writedata),
        .dest_write_en(dest_write_en), .spike_count(spike_count), .size_err(size_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rows; int cols; int cur; int step; int thr; int shift;
        bit mode; bit clr; bit poke; int exp_cnt; bit exp_err;
    } vec_t;

    typedef struct {
        logic [13:0] addr;
        logic [15:0] data;
    } exp_t;

    logic signed [15:0] srcmem [16384];
    logic signed [15:0] mdl_v [1024];
    exp_t sb_q[$];
    vec_t tbl[23];

    int chk = 0;
    int errs = 0;
    int cyc = 0;
    int t0 = 0;
    int wr_count = 0;
    int first_wr = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) src_readdata <= srcmem[src_address];

    task automatic check(input string name, input longint act, input longint exp);
        chk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every destination write is popped and compared
    always @(negedge clk) begin
        if (dest_write_en) begin
            wr_count++;
            if (first_wr < 0) first_wr = cyc - t0;
            chk++;
            if (sb_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard",
                         dest_address, dest_writedata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (dest_address !== e.addr || dest_writedata !== e.data) begin
                    errs++;
                    $display("FAIL sb_write: got addr %0d data %0d expected addr %0d data %0d",
                             dest_address, dest_writedata, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic signed [15:0] sat16(input int x);
        if (x > 32767) return 16'sh7fff;
        if (x < -32768) return -16'sh8000;
        return 16'(x);
    endfunction

    function automatic vec_t mk(input int r, input int c, input int cur, input int step,
                                input int thr, input int sh, input bit mode, input bit clr,
                                input bit poke, input int cnt, input bit err);
        vec_t v;
        v.rows = r; v.cols = c; v.cur = cur; v.step = step; v.thr = thr; v.shift = sh;
        v.mode = mode; v.clr = clr; v.poke = poke; v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    task automatic load_pass(input vec_t v, input logic [13:0] sb, input logic [13:0] db);
        int n;
        n = v.rows * v.cols;
        row_size = 10'(v.rows); col_size = 10'(v.cols);
        threshold = 16'(v.thr); leak_shift = 4'(v.shift);
        reset_mode = v.mode; clear_state = v.clr;
        src_start_address = sb; dest_start_address = db;
        if (v.exp_err) return;
        if (v.clr) for (int k = 0; k < n; k++) mdl_v[k] = '0;
        for (int k = 0; k < n; k++) begin
            int vv, vn;
            bit sp;
            exp_t e;
            srcmem[int'(sb) + k] = 16'(v.cur + k * v.step);
            vv = int'(mdl_v[k]);
            vn = int'(sat16(vv - (vv >>> v.shift) + v.cur + k * v.step));
            sp = (vn >= v.thr);
            mdl_v[k] = sp ? (v.mode ? sat16(vn - v.thr) : 16'sd0) : 16'(vn);
            e.addr = db + 14'(k);
            e.data = {15'd0, sp};
            sb_q.push_back(e);
        end
    endtask

    task automatic run_pass(input vec_t v, input int i);
        int n, c, exp_done, done_at;
        bit done_bad, src_bad;
        logic [13:0] sb, db;
        n = v.rows * v.cols;
        sb = 14'((i * 53) % 4000);
        db = 14'(8000 + i * 71);
        load_pass(v, sb, db);
        c = v.clr ? n : 0;
        exp_done = c + n + 3;
        wr_count = 0; first_wr = -1; t0 = cyc;
        done_bad = 0; src_bad = 0; done_at = -1;
        start = 1'b1;
        if (v.exp_err) begin
            for (int r = 1; r <= 6; r++) begin
                @(negedge clk);
                start = 1'b0;
                if (!done) done_bad = 1;
            end
            check($sformatf("p%0d size_err", i), size_err, 1);
            check($sformatf("p%0d done_stays_high", i), done_bad, 0);
            check($sformatf("p%0d no_writes", i), wr_count, 0);
            return;
        end
        for (int r = 1; r <= exp_done + 10 && done_at < 0; r++) begin
            @(negedge clk);
            start = (v.poke && r == 3);
            if (v.poke && r == 3) begin
                threshold = -16'sd1; src_start_address = '0; dest_start_address = '0;
                clear_state = ~clear_state; row_size = 10'd1;
            end
            if (done) done_at = r;
            if (r >= c + 1 && r <= c + n && src_address !== sb + 14'(r - c - 1)) src_bad = 1;
        end
        check($sformatf("p%0d done_cycle", i), done_at, exp_done);
        check($sformatf("p%0d first_write_cycle", i), first_wr, c + 3);
        check($sformatf("p%0d write_count", i), wr_count, n);
        check($sformatf("p%0d spike_count", i), spike_count, v.exp_cnt);
        check($sformatf("p%0d size_err_clear", i), size_err, 0);
        check($sformatf("p%0d src_address_seq_bad", i), src_bad, 0);
        check($sformatf("p%0d sb_leftover", i), sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        vec_t rv;
        // Integration with reset-to-zero: 5,10 silent, 15 fires everywhere
        tbl[0]  = mk(2, 3, 5, 0, 12, 15, 0, 1, 0, 0, 0);
        tbl[1]  = mk(2, 3, 5, 0, 12, 15, 0, 0, 0, 0, 0);
        tbl[2]  = mk(2, 3, 5, 0, 12, 15, 0, 0, 0, 6, 0);
        // Reset by subtraction: membrane 10, 4, 14, 8
        tbl[3]  = mk(1, 1, 10, 0, 16, 15, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 10, 0, 16, 15, 1, 0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 10, 0, 16, 15, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 10, 0, 16, 15, 1, 0, 0, 1, 0);
        // Leak converging to 16, never reaching 100
        tbl[7]  = mk(1, 1, 8, 0, 100, 1, 0, 1, 0, 0, 0);
        for (int p = 8; p <= 12; p++) tbl[p] = mk(1, 1, 8, 0, 100, 1, 0, 0, 0, 0, 0);
        // Positive then negative saturation (no wrap: -32767 stays below 0)
        tbl[13] = mk(1, 1, 20000, 0, 32767, 15, 0, 1, 0, 0, 0);
        tbl[14] = mk(1, 1, 20000, 0, 32767, 15, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 1, -30000, 0, 32767, 15, 0, 1, 0, 0, 0);
        tbl[16] = mk(1, 1, -30000, 0, 32767, 15, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 1, 0, 0, 0, 15, 0, 0, 0, 0, 0);
        // Ramp of currents -40..70; elements 7..11 reach 30; start/config poked mid-pass
        tbl[18] = mk(3, 4, -40, 10, 30, 2, 0, 1, 1, 5, 0);
        tbl[19] = mk(0, 5, 1, 0, 1, 15, 0, 1, 0, 0, 1);
        tbl[20] = mk(25, 41, 1, 0, 1, 15, 0, 1, 0, 0, 1);
        tbl[21] = mk(32, 32, 1, 0, 1, 15, 0, 1, 0, 1024, 0);
        tbl[22] = mk(1, 2, 3, 0, 2, 15, 0, 1, 0, 2, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", done, 1);
        check("rst_dest_write_en", dest_write_en, 0);
        check("rst_dest_writedata", dest_writedata, 0);
        check("rst_src_address", src_address, 0);
        check("rst_dest_address", dest_address, 0);
        check("rst_spike_count", spike_count, 0);
        check("rst_size_err", size_err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 23; i++) run_pass(tbl[i], i);

        // Reset asserted during cycle 4 of a 4x4 pass without clearing
        rv = mk(4, 4, 3, 1, 10, 15, 0, 0, 0, 0, 0);
        load_pass(rv, 14'd200, 14'd300);
        wr_count = 0; first_wr = -1; t0 = cyc;
        start = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            start = 1'b0;
            if (r == 4) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("midrst_done", done, 1);
        check("midrst_dest_write_en", dest_write_en, 0);
        check("midrst_writes_before", wr_count, 2);
        check("midrst_first_write", first_wr, 3);
        sb_q.delete();
        @(negedge clk);

        // Fresh pass after reset: currents 3..18, elements 7..15 fire
        run_pass(mk(4, 4, 3, 1, 10, 15, 0, 1, 0, 9, 0), 30);

        $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
        $finish;
    end

endmodule
